// File: rtl/alu_seq_if.sv
// Request/response bundle between the EX stage and the sequential ALU.
// The master drives the operation; the slave returns the result and NZCV flags.
interface alu_seq_if #(
  parameter int N = 64
);
  logic         start;
  logic [3:0]   AluControl;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         zero;
  logic         negative;
  logic         carry;
  logic         overflow;

  modport master (
    output start, AluControl, a, b,
    input  busy, done, result, zero, negative, carry, overflow
  );

  modport slave (
    input  start, AluControl, a, b,
    output busy, done, result, zero, negative, carry, overflow
  );
endinterface

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU: single-cycle logic/arith/shift ops, iterative
// shift-add MUL and restoring UDIV/SDIV behind a start/busy/done handshake.
module alu_seq #(
  parameter int N   = 64,
  parameter int SHW = $clog2(N)
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus
);

  localparam int CW = $clog2(N);
  localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_AND  = 4'b0000, OP_ORR  = 4'b0001, OP_ADD  = 4'b0010, OP_EOR  = 4'b0011,
    OP_LSL  = 4'b0100, OP_LSR  = 4'b0101, OP_SUB  = 4'b0110, OP_PASS = 4'b0111,
    OP_MUL  = 4'b1000, OP_UDIV = 4'b1001, OP_SDIV = 4'b1010
  } op_t;

  state_t        state, state_n;
  logic          mul_q, mul_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0]  ra, ra_n, rb, rb_n, acc, acc_n;
  logic [N-1:0]  res_q, res_n;
  logic          neg_q, neg_n, c_q, c_n, v_q, v_n;
  logic [N:0]    sum, diff, rem_t, rem_s;
  logic [N-1:0]  qfin, pfin;

  always_comb begin
    sum   = {1'b0, bus.a} + {1'b0, bus.b};
    diff  = {1'b0, bus.a} + {1'b0, ~bus.b} + {{N{1'b0}}, 1'b1};
    // ra doubles as dividend shifter and quotient collector during division
    rem_t = {acc, ra[N-1]};
    rem_s = rem_t - {1'b0, rb};
    qfin  = {ra[N-2:0], ~rem_s[N]};
    pfin  = rb[0] ? acc + ra : acc;

    state_n = state;
    mul_n   = mul_q;
    cnt_n   = cnt;
    ra_n    = ra;
    rb_n    = rb;
    acc_n   = acc;
    neg_n   = neg_q;
    res_n   = res_q;
    c_n     = c_q;
    v_n     = v_q;

    case (state)
      S_CALC: begin
        cnt_n = cnt + CW'(1);
        if (mul_q) begin
          acc_n = pfin;
          ra_n  = ra << 1;
          rb_n  = rb >> 1;
        end else begin
          ra_n  = qfin;
          acc_n = rem_s[N] ? rem_t[N-1:0] : rem_s[N-1:0];
        end
        if (cnt == CW'(N-1)) begin
          state_n = S_DONE;
          c_n     = 1'b0;
          v_n     = 1'b0;
          res_n   = mul_q ? pfin : (neg_q ? -qfin : qfin);
        end
      end
      default: begin
        state_n = S_IDLE;
        if (bus.start) begin
          state_n = S_DONE;
          c_n     = 1'b0;
          v_n     = 1'b0;
          case (op_t'(bus.AluControl))
            OP_AND:  res_n = bus.a & bus.b;
            OP_ORR:  res_n = bus.a | bus.b;
            OP_EOR:  res_n = bus.a ^ bus.b;
            OP_PASS: res_n = bus.b;
            OP_LSL:  res_n = bus.a << bus.b[SHW-1:0];
            OP_LSR:  res_n = bus.a >> bus.b[SHW-1:0];
            OP_ADD: begin
              res_n = sum[N-1:0];
              c_n   = sum[N];
              v_n   = (bus.a[N-1] == bus.b[N-1]) && (sum[N-1] != bus.a[N-1]);
            end
            OP_SUB: begin
              res_n = diff[N-1:0];
              c_n   = diff[N];
              v_n   = (bus.a[N-1] != bus.b[N-1]) && (diff[N-1] != bus.a[N-1]);
            end
            OP_MUL: begin
              state_n = S_CALC;
              mul_n   = 1'b1;
              cnt_n   = '0;
              ra_n    = bus.a;
              rb_n    = bus.b;
              acc_n   = '0;
              neg_n   = 1'b0;
            end
            OP_UDIV: begin
              if (bus.b == '0) begin
                res_n = '0;
              end else begin
                state_n = S_CALC;
                mul_n   = 1'b0;
                cnt_n   = '0;
                ra_n    = bus.a;
                rb_n    = bus.b;
                acc_n   = '0;
                neg_n   = 1'b0;
              end
            end
            OP_SDIV: begin
              if (bus.b == '0) begin
                res_n = '0;
              end else if (bus.a == MINV && bus.b == '1) begin
                res_n = bus.a;
              end else begin
                state_n = S_CALC;
                mul_n   = 1'b0;
                cnt_n   = '0;
                ra_n    = bus.a[N-1] ? -bus.a : bus.a;
                rb_n    = bus.b[N-1] ? -bus.b : bus.b;
                acc_n   = '0;
                neg_n   = bus.a[N-1] ^ bus.b[N-1];
              end
            end
            default: res_n = '1;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      mul_q <= 1'b0;
      cnt   <= '0;
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
      neg_q <= 1'b0;
      res_q <= '0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      state <= state_n;
      mul_q <= mul_n;
      cnt   <= cnt_n;
      ra    <= ra_n;
      rb    <= rb_n;
      acc   <= acc_n;
      neg_q <= neg_n;
      res_q <= res_n;
      c_q   <= c_n;
      v_q   <= v_n;
    end
  end

  assign bus.busy     = (state == S_CALC);
  assign bus.done     = (state == S_DONE);
  assign bus.result   = res_q;
  assign bus.zero     = (res_q == '0);
  assign bus.negative = res_q[N-1];
  assign bus.carry    = c_q;
  assign bus.overflow = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq (N=64) against an arithmetic
// reference model of the opcode set, flags and latency.
module tb_alu_seq;

  localparam int N = 64;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  alu_seq_if #(.N(N)) bus ();

  alu_seq #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic void model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output logic c, output logic v,
                                output int lat);
    logic [64:0] w;
    lat = 1;
    c   = 1'b0;
    v   = 1'b0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd3: r = a ^ b;
      4'd7: r = b;
      4'd4: r = a << b[5:0];
      4'd5: r = a >> b[5:0];
      4'd2: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[63:0];
        c = w[64];
        v = (($signed(a) < 0) == ($signed(b) < 0)) && (($signed(r) < 0) != ($signed(a) < 0));
      end
      4'd6: begin
        r = a - b;
        c = (a >= b);
        v = (($signed(a) < 0) != ($signed(b) < 0)) && (($signed(r) < 0) != ($signed(a) < 0));
      end
      4'd8: begin r = a * b; lat = N + 1; end
      4'd9: begin
        if (b == 0) r = '0;
        else begin r = a / b; lat = N + 1; end
      end
      4'd10: begin
        if (b == 0) r = '0;
        else if (a == MINV && b == '1) r = a;
        else begin r = 64'($signed(a) / $signed(b)); lat = N + 1; end
      end
      default: r = '1;
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] er;
    logic        ec, ev;
    int          elat, cycles;
    model(op, a, b, er, ec, ev, elat);
    @(negedge clk);
    bus.start = 1'b1; bus.AluControl = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.AluControl = 4'($urandom);
    bus.a = {$urandom, $urandom};
    bus.b = {$urandom, $urandom};
    cycles = 1;
    while (!bus.done && cycles < 200) begin
      if (bus.busy) begin
        bus.start = 1'($urandom);
        bus.AluControl = 4'($urandom);
        bus.a = {$urandom, $urandom};
      end
      @(posedge clk); #1;
      cycles++;
    end
    bus.start = 1'b0;
    check({tag, " lat"},   64'(cycles),        64'(elat));
    check({tag, " res"},   bus.result,         er);
    check({tag, " Z"},     64'(bus.zero),      64'(er == 0));
    check({tag, " N"},     64'(bus.negative),  64'(er[63]));
    check({tag, " C"},     64'(bus.carry),     64'(ec));
    check({tag, " V"},     64'(bus.overflow),  64'(ev));
  endtask

  initial begin
    int          opset[13];
    logic [63:0] ra, rb, er;
    logic        ec, ev;
    int          elat;
    opset = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 15};
    n_chk = 0;
    n_pass = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.AluControl = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 64'(bus.busy), 64'(0));
    check("rst done", 64'(bus.done), 64'(0));
    check("rst res",  bus.result,    64'(0));
    check("rst Z",    64'(bus.zero), 64'(1));
    check("rst NCV",  {61'(0), bus.negative, bus.carry, bus.overflow}, 64'(0));
    @(negedge clk);
    reset = 1'b1;

    do_op("add57",   4'b0010, 64'd5, 64'd7);
    do_op("sub33",   4'b0110, 64'd3, 64'd3);
    do_op("addovf",  4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    do_op("mul",     4'b1000, -64'sd3, 64'd7);
    do_op("udiv",    4'b1001, 64'd100, 64'd7);
    do_op("sdiv",    4'b1010, -64'sd100, 64'd7);
    do_op("udiv0",   4'b1001, 64'hDEAD_BEEF, 64'd0);
    do_op("sdivmin", 4'b1010, MINV, '1);
    check("mul const", bus.result == 64'hFFFF_FFFF_FFFF_FFEB ? 64'd1 : 64'd0, 64'd0) ;

    // back-to-back: start held through ADD, ORR, LSL
    @(negedge clk);
    bus.start = 1'b1; bus.AluControl = 4'b0010; bus.a = 64'd5; bus.b = 64'd7;
    @(posedge clk); #1;
    check("b2b add done", 64'(bus.done), 64'(1));
    check("b2b add res",  bus.result, 64'd12);
    bus.AluControl = 4'b0001; bus.a = 64'hF0; bus.b = 64'h0F;
    @(posedge clk); #1;
    check("b2b orr done", 64'(bus.done), 64'(1));
    check("b2b orr res",  bus.result, 64'hFF);
    bus.AluControl = 4'b0100; bus.a = 64'd1; bus.b = 64'd70;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b lsl done", 64'(bus.done), 64'(1));
    check("b2b lsl res",  bus.result, 64'd64);
    @(posedge clk); #1;
    check("b2b idle", 64'(bus.done), 64'(0));

    // reset during a division
    @(negedge clk);
    bus.start = 1'b1; bus.AluControl = 4'b1001; bus.a = 64'd1000; bus.b = 64'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("mid busy", 64'(bus.busy), 64'(1));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("abort busy", 64'(bus.busy), 64'(0));
    check("abort done", 64'(bus.done), 64'(0));
    check("abort res",  bus.result,    64'(0));
    check("abort Z",    64'(bus.zero), 64'(1));
    @(negedge clk);
    reset = 1'b1;
    do_op("postrst", 4'b1001, 64'd1000, 64'd3);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = 4'(opset[$urandom_range(0, 12)]);
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: rb = 64'($urandom_range(0, 7));
        1: rb = '1;
        2: rb = 64'($urandom);
        default: rb = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 5) == 0) ra = MINV;
      do_op("rand", op, ra, rb);
    end

    model(4'b1000, -64'sd3, 64'd7, er, ec, ev, elat);
    check("model mul", er, 64'hFFFF_FFFF_FFFF_FFEB);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
